// File: rtl/asynchronous_up_down_counter_pkg.sv
// Shared constants for the ripple up/down counter.
package async_cnt_pkg;

    localparam int ASYNC_CNT_WIDTH = 4;

endpackage

// File: rtl/asynchronous_up_down_counter_if.sv
// Direction/count bundle for the ripple counter; tc only exists with ASYNC_CNT_TC_EN.
interface async_cnt_if
    import async_cnt_pkg::*;
#(
    parameter int WIDTH = ASYNC_CNT_WIDTH
);

    logic             up;
    logic [WIDTH-1:0] count;
`ifdef ASYNC_CNT_TC_EN
    logic             tc;

    modport master (output up, input  count, input  tc);
    modport slave  (input  up, output count, output tc);
`else
    modport master (output up, input  count);
    modport slave  (input  up, output count);
`endif

endinterface

// File: rtl/asynchronous_up_down_counter_ripple_tff_stage.sv
// One ripple stage: a T flip-flop with asynchronous active-high clear.
module ripple_tff_stage (
    input  logic clk,
    input  logic reset,
    output logic q
);

    // NOTE: sequential state always uses non-blocking assignment so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= 1'b0;
        else       q <= ~q;
    end

endmodule

// File: rtl/asynchronous_up_down_counter.sv
// Ripple binary up/down counter: stage 0 runs on clk, stage i on a clock derived
// from stage i-1 and up. Optional terminal-count output under ASYNC_CNT_TC_EN.
module asynchronous_up_down_counter
    import async_cnt_pkg::*;
#(
    parameter int WIDTH = ASYNC_CNT_WIDTH
) (
    input  logic             up,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count
`ifdef ASYNC_CNT_TC_EN
    ,
    output logic             tc
`endif
);

    if (WIDTH < 2) begin : g_width_check
        $error("asynchronous_up_down_counter: WIDTH must be at least 2");
    end

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] sclk;

    assign sclk[0] = clk;

    // Flipping up re-derives every stage clock; a resulting rising edge toggles
    // that stage. This direction-change artifact is intended behaviour.
    for (genvar i = 1; i < WIDTH; i++) begin : g_sclk
        assign sclk[i] = up ? ~q[i-1] : q[i-1];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        ripple_tff_stage u_stage (
            .clk   (sclk[i]),
            .reset (reset),
            .q     (q[i])
        );
    end

    assign count = q;

`ifdef ASYNC_CNT_TC_EN
    assign tc = up ? (&q) : ~(|q);
`endif

endmodule

// File: tb/tb_asynchronous_up_down_counter.sv
// Directed self-checking bench for the ripple up/down counter (clk period 10).
module tb_asynchronous_up_down_counter;
    import async_cnt_pkg::*;

    localparam int W = ASYNC_CNT_WIDTH;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    async_cnt_if #(.WIDTH(W)) bus ();

    asynchronous_up_down_counter #(.WIDTH(W)) dut (
        .up    (bus.up),
        .clk   (clk),
        .reset (reset),
        .count (bus.count)
`ifdef ASYNC_CNT_TC_EN
        ,
        .tc    (bus.tc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_tc(input string tag, input logic expected);
`ifdef ASYNC_CNT_TC_EN
        checks++;
        assert (bus.tc === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, bus.tc, expected);
        end
`endif
    endtask

    // Sample one time unit after the rising edge, once the ripple has settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset at t=0, release between edges, then count up.
        reset  = 1'b1;
        bus.up = 1'b1;
        #1 check("reset_hold", int'(bus.count), 0);
        check_tc("tc_in_reset", 1'b0);
        #2 reset = 1'b0;
        #1 check("reset_released", int'(bus.count), 0);
        tick(); check("up_1", int'(bus.count), 1);
        tick(); check("up_2", int'(bus.count), 2);
        tick(); check("up_3", int'(bus.count), 3);
        tick(); check("up_4", int'(bus.count), 4);

        // Direction change at t=43 with count=4 gives the 4 -> 12 artifact.
        #7 bus.up = 1'b0;
        #1 check("dir_artifact", int'(bus.count), 12);
        tick(); check("down_11", int'(bus.count), 11);
        tick(); check("down_10", int'(bus.count), 10);
        tick(); check("down_9", int'(bus.count), 9);

        // Wrap 15 -> 0 going up; direction flip at 0 leaves 0; then 0 -> 15 -> 14.
        #2 reset = 1'b1;
        #1 check("reset_mid", int'(bus.count), 0);
        bus.up = 1'b1;
        #1 reset = 1'b0;
        repeat (14) tick();
        tick(); check("up_15", int'(bus.count), 15);
        check_tc("tc_up_full", 1'b1);
        tick(); check("wrap_up_0", int'(bus.count), 0);
        check_tc("tc_up_zero", 1'b0);
        #2 bus.up = 1'b0;
        #1 check("flip_at_zero", int'(bus.count), 0);
        check_tc("tc_down_zero", 1'b1);
        tick(); check("wrap_down_15", int'(bus.count), 15);
        check_tc("tc_down_full", 1'b0);
        tick(); check("down_14", int'(bus.count), 14);

        // Short reset pulse between edges with count=7.
        #2 reset = 1'b1;
        bus.up = 1'b1;
        #1 reset = 1'b0;
        repeat (7) tick();
        check("up_7", int'(bus.count), 7);
        #2 reset = 1'b1;
        #1 check("pulse_clear", int'(bus.count), 0);
        #1 reset = 1'b0;
        tick(); check("after_pulse_1", int'(bus.count), 1);

        // Reset held across several edges keeps count at 0.
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check("reset_held", int'(bus.count), 0);
        end
        #2 reset = 1'b0;
        tick(); check("after_held_1", int'(bus.count), 1);
        tick(); check("after_held_2", int'(bus.count), 2);

        // Reset asserted at the same instant as a clk edge wins.
        @(posedge clk);
        reset = 1'b1;
        #1 check("edge_reset", int'(bus.count), 0);
        #2 reset = 1'b0;
        tick(); check("after_edge_reset", int'(bus.count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
